// File: rtl/lp4_mc_pkg.sv
// Shared LPDDR4 controller definitions: command encodings,
// address bit meanings and the refresh engine state type.
package lp4_mc_pkg;

    // Command encodings packed as {cas, ras, we}
    localparam logic [2:0] CMD_PRE_ALL = 3'b011;
    localparam logic [2:0] CMD_REF     = 3'b110;

    localparam int A_ALLBANK_BIT = 10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_GNT,
        ST_PRE_ALL,
        ST_WAIT_TRP,
        ST_REF,
        ST_WAIT_TRFC
    } ref_state_t;

endpackage

// File: rtl/refresh_delay_timer.sv
// Load/countdown timer shared by the tRP and tRFC waits.
// done is registered so a load of N releases the FSM N cycles later.
module refresh_delay_timer (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic       load,
    input  logic [7:0] value,
    output logic       done
);

    logic [7:0] cnt;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            cnt  <= 8'd0;
            done <= 1'b0;
        end else if (load) begin
            cnt  <= value;
            done <= (value <= 8'd1);
        end else if (cnt > 8'd1) begin
            cnt  <= cnt - 8'd1;
            done <= (cnt == 8'd2);
        end
    end

endmodule

// File: rtl/refresher_lp4.sv
// Periodic all-bank refresh engine: interval timer, pending queue
// and the request/grant, PRECHARGE-ALL, REFRESH command sequence.
module refresher_lp4
    import lp4_mc_pkg::*;
#(
    parameter int NUM_BANKS   = 8,
    parameter int TREFI_W     = 16,
    parameter int MAX_PENDING = 8
) (
    input  logic               sys_clk,
    input  logic               sys_rst_n,
    input  logic               refresh_en,
    output logic               refresh_req,
    input  logic [NUM_BANKS-1:0] refresh_gnt,
    output logic               cmd_valid,
    input  logic               cmd_ready,
    output logic [16:0]        cmd_payload_a,
    output logic [2:0]         cmd_payload_ba,
    output logic               cmd_payload_cas,
    output logic               cmd_payload_ras,
    output logic               cmd_payload_we,
    output logic               cmd_payload_is_cmd,
    output logic               cmd_payload_is_read,
    output logic               cmd_payload_is_write,
    input  logic [TREFI_W-1:0] tREFI_cfg,
    input  logic [7:0]         tRP_cfg,
    input  logic [7:0]         tRFC_cfg,
    output logic               busy,
    output logic [3:0]         pending,
    output logic               refresh_overflow
);

    localparam logic [16:0] A_PRE_ALL = 17'h1 << A_ALLBANK_BIT;
    localparam logic [3:0]  PEND_MAX  = 4'(MAX_PENDING);

    ref_state_t         state;
    logic [TREFI_W-1:0] timer;
    logic               tick;
    logic               delay_load;
    logic [7:0]         delay_val;
    logic               delay_done;
    logic               ref_acc;

    assign tick       = refresh_en && (timer == TREFI_W'(1));
    assign ref_acc    = (state == ST_REF) && cmd_ready;
    assign delay_load = ((state == ST_PRE_ALL) || (state == ST_REF))
                        && cmd_ready;
    assign delay_val  = (state == ST_REF) ? tRFC_cfg : tRP_cfg;

    assign cmd_payload_ba       = 3'd0;
    assign cmd_payload_is_cmd   = cmd_valid;
    assign cmd_payload_is_read  = 1'b0;
    assign cmd_payload_is_write = 1'b0;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            timer <= '0;
        end else if (!refresh_en) begin
            timer <= '0;
        end else if (timer == '0 || timer == TREFI_W'(1)) begin
            timer <= tREFI_cfg;
        end else begin
            timer <= timer - TREFI_W'(1);
        end
    end

    // Simultaneous tick and accept cancel out
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            pending          <= 4'd0;
            refresh_overflow <= 1'b0;
        end else begin
            unique case ({tick, ref_acc})
                2'b10: begin
                    if (pending == PEND_MAX) refresh_overflow <= 1'b1;
                    else                     pending <= pending + 4'd1;
                end
                2'b01:   pending <= pending - 4'd1;
                default: ;
            endcase
        end
    end

    refresh_delay_timer u_delay (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .load      (delay_load),
        .value     (delay_val),
        .done      (delay_done)
    );

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state           <= ST_IDLE;
            refresh_req     <= 1'b0;
            busy            <= 1'b0;
            cmd_valid       <= 1'b0;
            cmd_payload_a   <= 17'd0;
            cmd_payload_cas <= 1'b0;
            cmd_payload_ras <= 1'b0;
            cmd_payload_we  <= 1'b0;
        end else begin
            unique case (state)
                ST_IDLE: if (pending != 4'd0) begin
                    state       <= ST_WAIT_GNT;
                    refresh_req <= 1'b1;
                    busy        <= 1'b1;
                end
                ST_WAIT_GNT: if (&refresh_gnt) begin
                    state         <= ST_PRE_ALL;
                    cmd_valid     <= 1'b1;
                    cmd_payload_a <= A_PRE_ALL;
                    {cmd_payload_cas, cmd_payload_ras, cmd_payload_we}
                        <= CMD_PRE_ALL;
                end
                ST_PRE_ALL: if (cmd_ready) begin
                    state         <= ST_WAIT_TRP;
                    cmd_valid     <= 1'b0;
                    cmd_payload_a <= 17'd0;
                    {cmd_payload_cas, cmd_payload_ras, cmd_payload_we}
                        <= 3'b000;
                end
                ST_WAIT_TRP: if (delay_done) begin
                    state         <= ST_REF;
                    cmd_valid     <= 1'b1;
                    cmd_payload_a <= 17'd0;
                    {cmd_payload_cas, cmd_payload_ras, cmd_payload_we}
                        <= CMD_REF;
                end
                ST_REF: if (cmd_ready) begin
                    state     <= ST_WAIT_TRFC;
                    cmd_valid <= 1'b0;
                    {cmd_payload_cas, cmd_payload_ras, cmd_payload_we}
                        <= 3'b000;
                end
                ST_WAIT_TRFC: if (delay_done) begin
                    state       <= ST_IDLE;
                    refresh_req <= 1'b0;
                    busy        <= 1'b0;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_refresher_lp4.sv
// Directed scenario bench for refresher_lp4 with hand-computed
// cycle positions counted from the first enabled clock edge.
module tb_refresher_lp4;

    logic        sys_clk = 1'b0;
    logic        sys_rst_n = 1'b0;
    logic        refresh_en = 1'b0;
    logic        refresh_req;
    logic [7:0]  refresh_gnt = 8'hFF;
    logic        cmd_valid;
    logic        cmd_ready = 1'b1;
    logic [16:0] cmd_payload_a;
    logic [2:0]  cmd_payload_ba;
    logic        cmd_payload_cas;
    logic        cmd_payload_ras;
    logic        cmd_payload_we;
    logic        cmd_payload_is_cmd;
    logic        cmd_payload_is_read;
    logic        cmd_payload_is_write;
    logic [15:0] tREFI_cfg = 16'd100;
    logic [7:0]  tRP_cfg = 8'd3;
    logic [7:0]  tRFC_cfg = 8'd5;
    logic        busy;
    logic [3:0]  pending;
    logic        refresh_overflow;

    int errors = 0;
    int checks = 0;

    logic [33:0] outs;
    logic [2:0]  crw;
    assign outs = {refresh_req, cmd_valid, cmd_payload_a, cmd_payload_ba,
                   cmd_payload_cas, cmd_payload_ras, cmd_payload_we,
                   cmd_payload_is_cmd, cmd_payload_is_read,
                   cmd_payload_is_write, busy, pending, refresh_overflow};
    assign crw = {cmd_payload_cas, cmd_payload_ras, cmd_payload_we};

    always #5 sys_clk = ~sys_clk;

    refresher_lp4 dut (
        .sys_clk              (sys_clk),
        .sys_rst_n            (sys_rst_n),
        .refresh_en           (refresh_en),
        .refresh_req          (refresh_req),
        .refresh_gnt          (refresh_gnt),
        .cmd_valid            (cmd_valid),
        .cmd_ready            (cmd_ready),
        .cmd_payload_a        (cmd_payload_a),
        .cmd_payload_ba       (cmd_payload_ba),
        .cmd_payload_cas      (cmd_payload_cas),
        .cmd_payload_ras      (cmd_payload_ras),
        .cmd_payload_we       (cmd_payload_we),
        .cmd_payload_is_cmd   (cmd_payload_is_cmd),
        .cmd_payload_is_read  (cmd_payload_is_read),
        .cmd_payload_is_write (cmd_payload_is_write),
        .tREFI_cfg            (tREFI_cfg),
        .tRP_cfg              (tRP_cfg),
        .tRFC_cfg             (tRFC_cfg),
        .busy                 (busy),
        .pending              (pending),
        .refresh_overflow     (refresh_overflow)
    );

    task automatic step(input int n);
        repeat (n) @(negedge sys_clk);
    endtask

    task automatic do_reset();
        @(negedge sys_clk);
        sys_rst_n   = 1'b0;
        refresh_en  = 1'b0;
        refresh_gnt = 8'hFF;
        cmd_ready   = 1'b1;
        tREFI_cfg   = 16'd100;
        tRP_cfg     = 8'd3;
        tRFC_cfg    = 8'd5;
        step(2);
        sys_rst_n = 1'b1;
        step(1);
    endtask

    task automatic test_reset();
        step(1);
        checks++;
        if (outs !== 34'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %h want 0", outs);
        end
        sys_rst_n = 1'b1;
        step(3);
        checks++;
        if (outs !== 34'd0) begin
            errors++;
            $display("FAIL idle_disabled: got %h want 0", outs);
        end
    endtask

    task automatic test_interval();
        do_reset();
        refresh_en = 1'b1;
        step(101);
        checks++;
        if (refresh_req !== 1'b0 || pending !== 4'd1) begin
            errors++;
            $display("FAIL t1_tick100: req=%b pend=%0d want 0/1",
                     refresh_req, pending);
        end
        step(1);
        checks++;
        if (refresh_req !== 1'b1 || cmd_valid !== 1'b0) begin
            errors++;
            $display("FAIL t1_req101: req=%b valid=%b want 1/0",
                     refresh_req, cmd_valid);
        end
        step(1);
        checks++;
        if (cmd_valid !== 1'b1 || cmd_payload_a !== 17'h400 ||
            crw !== 3'b011 || cmd_payload_is_cmd !== 1'b1) begin
            errors++;
            $display("FAIL t1_pre102: v=%b a=%h crw=%b want 1/400/011",
                     cmd_valid, cmd_payload_a, crw);
        end
        step(4);
        checks++;
        if (cmd_valid !== 1'b1 || cmd_payload_a !== 17'h0 ||
            crw !== 3'b110) begin
            errors++;
            $display("FAIL t1_ref106: v=%b a=%h crw=%b want 1/0/110",
                     cmd_valid, cmd_payload_a, crw);
        end
        step(1);
        checks++;
        if (pending !== 4'd0 || cmd_valid !== 1'b0) begin
            errors++;
            $display("FAIL t1_accept107: pend=%0d v=%b want 0/0",
                     pending, cmd_valid);
        end
        step(4);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL t1_busy111: got %b want 1", busy);
        end
        step(1);
        checks++;
        if (busy !== 1'b0 || refresh_req !== 1'b0) begin
            errors++;
            $display("FAIL t1_idle112: busy=%b req=%b want 0/0",
                     busy, refresh_req);
        end
        refresh_en = 1'b0;
    endtask

    task automatic test_grant_wait();
        logic bad;
        bad = 1'b0;
        do_reset();
        tREFI_cfg   = 16'd10;
        refresh_gnt = 8'hDF;
        refresh_en  = 1'b1;
        for (int i = 0; i < 40 && refresh_req !== 1'b1; i++) step(1);
        refresh_en = 1'b0;
        checks++;
        if (refresh_req !== 1'b1) begin
            errors++;
            $display("FAIL t2_req_timeout: got %b want 1", refresh_req);
        end
        for (int i = 0; i < 20; i++) begin
            if (i == 5) refresh_gnt = 8'h00;
            if (i == 8) refresh_gnt = 8'hDF;
            step(1);
            if (cmd_valid !== 1'b0) bad = 1'b1;
        end
        checks++;
        if (bad !== 1'b0 || refresh_req !== 1'b1) begin
            errors++;
            $display("FAIL t2_no_cmd: bad=%b req=%b want 0/1",
                     bad, refresh_req);
        end
        refresh_gnt = 8'hFF;
        step(1);
        checks++;
        if (cmd_valid !== 1'b1 || cmd_payload_a !== 17'h400) begin
            errors++;
            $display("FAIL t2_pre_after_gnt: v=%b a=%h want 1/400",
                     cmd_valid, cmd_payload_a);
        end
    endtask

    task automatic test_backpressure();
        logic bad;
        do_reset();
        cmd_ready  = 1'b0;
        tREFI_cfg  = 16'd5;
        tRP_cfg    = 8'd2;
        tRFC_cfg   = 8'd2;
        refresh_en = 1'b1;
        for (int i = 0; i < 30 && cmd_valid !== 1'b1; i++) step(1);
        refresh_en = 1'b0;
        bad = 1'b0;
        for (int i = 0; i < 7; i++) begin
            step(1);
            if (cmd_valid !== 1'b1 || cmd_payload_a !== 17'h400 ||
                crw !== 3'b011) bad = 1'b1;
        end
        checks++;
        if (bad !== 1'b0) begin
            errors++;
            $display("FAIL t3_pre_hold: unstable=%b want 0", bad);
        end
        cmd_ready = 1'b1;
        step(1);
        cmd_ready = 1'b0;
        step(1);
        checks++;
        if (cmd_valid !== 1'b0) begin
            errors++;
            $display("FAIL t3_trp_gap: v=%b want 0", cmd_valid);
        end
        step(1);
        checks++;
        if (cmd_valid !== 1'b1 || crw !== 3'b110 ||
            cmd_payload_a !== 17'h0) begin
            errors++;
            $display("FAIL t3_ref_time: v=%b crw=%b want 1/110",
                     cmd_valid, crw);
        end
        bad = 1'b0;
        for (int i = 0; i < 7; i++) begin
            step(1);
            if (cmd_valid !== 1'b1 || crw !== 3'b110 ||
                cmd_payload_a !== 17'h0) bad = 1'b1;
        end
        checks++;
        if (bad !== 1'b0) begin
            errors++;
            $display("FAIL t3_ref_hold: unstable=%b want 0", bad);
        end
        cmd_ready = 1'b1;
        step(1);
        cmd_ready = 1'b0;
        step(1);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL t3_trfc_busy: got %b want 1", busy);
        end
        step(1);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL t3_trfc_idle: got %b want 0", busy);
        end
    endtask

    task automatic test_saturate_drain();
        logic bad;
        logic prev_req;
        int   falls;
        do_reset();
        tREFI_cfg   = 16'd4;
        refresh_gnt = 8'h00;
        refresh_en  = 1'b1;
        step(50);
        checks++;
        if (pending !== 4'd8 || refresh_overflow !== 1'b1 ||
            cmd_valid !== 1'b0) begin
            errors++;
            $display("FAIL t4_saturate: pend=%0d ovf=%b v=%b want 8/1/0",
                     pending, refresh_overflow, cmd_valid);
        end
        refresh_en  = 1'b0;
        tRP_cfg     = 8'd1;
        tRFC_cfg    = 8'd1;
        refresh_gnt = 8'hFF;
        bad      = 1'b0;
        falls    = 0;
        prev_req = refresh_req;
        for (int i = 0; i < 200; i++) begin
            step(1);
            if (!prev_req && pending != 4'd0 && refresh_req !== 1'b1)
                bad = 1'b1;
            if (prev_req && !refresh_req) begin
                falls++;
                if (pending !== 4'(8 - falls)) bad = 1'b1;
            end
            prev_req = refresh_req;
            if (pending == 4'd0 && busy == 1'b0) break;
        end
        checks++;
        if (falls != 8 || bad !== 1'b0 || pending !== 4'd0) begin
            errors++;
            $display("FAIL t4_drain: falls=%0d bad=%b pend=%0d want 8/0/0",
                     falls, bad, pending);
        end
        checks++;
        if (refresh_overflow !== 1'b1) begin
            errors++;
            $display("FAIL t4_ovf_sticky: got %b want 1", refresh_overflow);
        end
    endtask

    task automatic test_min_delay();
        do_reset();
        tREFI_cfg  = 16'd3;
        tRP_cfg    = 8'd0;
        tRFC_cfg   = 8'd1;
        refresh_en = 1'b1;
        for (int i = 0; i < 20 && refresh_req !== 1'b1; i++) step(1);
        refresh_en = 1'b0;
        for (int i = 0; i < 20 && cmd_valid !== 1'b1; i++) step(1);
        checks++;
        if (cmd_valid !== 1'b1 || crw !== 3'b011) begin
            errors++;
            $display("FAIL t5_pre: v=%b crw=%b want 1/011", cmd_valid, crw);
        end
        step(2);
        checks++;
        if (cmd_valid !== 1'b1 || crw !== 3'b110) begin
            errors++;
            $display("FAIL t5_trp0: v=%b crw=%b want 1/110", cmd_valid, crw);
        end
        step(1);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL t5_trfc_busy: got %b want 1", busy);
        end
        step(1);
        checks++;
        if (busy !== 1'b0 || pending !== 4'd0) begin
            errors++;
            $display("FAIL t5_trfc1: busy=%b pend=%0d want 0/0",
                     busy, pending);
        end
    endtask

    task automatic test_reset_mid();
        logic bad;
        do_reset();
        tREFI_cfg  = 16'd3;
        tRP_cfg    = 8'd1;
        tRFC_cfg   = 8'd50;
        refresh_en = 1'b1;
        for (int i = 0; i < 30 && !(cmd_valid === 1'b1 &&
             cmd_payload_cas === 1'b1); i++) step(1);
        refresh_en = 1'b0;
        step(3);
        checks++;
        if (busy !== 1'b1 || cmd_valid !== 1'b0) begin
            errors++;
            $display("FAIL t6_in_trfc: busy=%b v=%b want 1/0",
                     busy, cmd_valid);
        end
        #2 sys_rst_n = 1'b0;
        #1;
        checks++;
        if (outs !== 34'd0) begin
            errors++;
            $display("FAIL t6_async_reset: got %h want 0", outs);
        end
        step(1);
        sys_rst_n = 1'b1;
        bad = 1'b0;
        for (int i = 0; i < 60; i++) begin
            step(1);
            if (cmd_valid !== 1'b0 || busy !== 1'b0 || pending !== 4'd0)
                bad = 1'b1;
        end
        checks++;
        if (bad !== 1'b0) begin
            errors++;
            $display("FAIL t6_no_reissue: activity=%b want 0", bad);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: sim time %0t exceeded limit", $time);
        $fatal(1);
    end

    initial begin
        test_reset();
        test_interval();
        test_grant_wait();
        test_backpressure();
        test_saturate_drain();
        test_min_delay();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
